ahb_master_burst: RTL and testbench
===================================

AHB_MASTER_BURST -- requirements
Module: ahb_master

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; all other ports are listed in REQ-002..REQ-018 as: name, direction, width, meaning.
REQ-002 CLK_MASTER  in  1  rising-edge clock for all logic.
REQ-003 RESET_MASTER  in  1  asynchronous active-low reset.
REQ-004 HREADY  in  1  slave ready; 1 completes the current data phase and advances the pipeline.
REQ-005 HRDATA  in  32  slave read data, valid in a read data phase when HREADY=1.
REQ-006 data_top  in  32  write data pushed into the write FIFO.
REQ-007 addr_top  in  32  burst start address.
REQ-008 write_top  in  1  1 = write burst and FIFO push enable; 0 = read burst.
REQ-009 beat_length  in  4  beats per burst (0 means 16).
REQ-010 enb  in  1  burst request, sampled in IDLE.
REQ-011 wrap_enb  in  1  1 = wrapping burst, 0 = incrementing burst.
REQ-012 HADDR  out  32  address-phase address.
REQ-013 HWRITE  out  1  transfer direction.
REQ-014 HSIZE  out  3  fixed 3'b010 (word).
REQ-015 HBURST  out  3  burst type.
REQ-016 HTRANS  out  2  IDLE 00, BUSY 01, NONSEQ 10, SEQ 11.
REQ-017 HWDATA  out  32  data-phase write data.
REQ-018 fifo_full / fifo_empty  out  1 each  write-FIFO status; rdata_top out 32 with rdata_valid out 1 carry captured read data and its one-cycle strobe.

Function
REQ-019 The write FIFO SHALL be 16 x 32 and push data_top on each clock where write_top=1 and fifo_full=0; a push while full SHALL be dropped.
REQ-020 Simultaneous push and pop SHALL both take effect with the count unchanged; fifo_full asserts at count 16 and fifo_empty at count 0.
REQ-021 The state machine SHALL have states IDLE, NONSEQ, SEQ and BUSY, and all outputs SHALL be registered.
REQ-022 In IDLE with enb=1 the block SHALL latch addr_top, write_top, beat_length and wrap_enb, then enter NONSEQ next cycle; a write request with fifo_empty=1 SHALL wait in IDLE.
REQ-023 enb SHALL be ignored outside IDLE.
REQ-024 HBURST SHALL be derived from the latched beat length: 1 -> SINGLE 000; 4 -> WRAP4 010 / INCR4 011; 8 -> WRAP8 100 / INCR8 101; 0 (16 beats) -> WRAP16 110 / INCR16 111; any other length -> INCR 001, with wrap_enb ignored and exactly that many beats issued.
REQ-025 The first beat SHALL use HTRANS=NONSEQ at the latched address; later beats SHALL use SEQ.
REQ-026 The address and beat counter SHALL advance only on a clock where HREADY=1, and all address-phase outputs SHALL hold while HREADY=0.
REQ-027 An incrementing burst's next address SHALL be HADDR+4 (32-bit modulo).
REQ-028 A wrapping burst with S = beats*4 SHALL use next address (HADDR & ~(S-1)) | ((HADDR+4) & (S-1)).
REQ-029 Write data phase: on the clock where HREADY=1 and a write NONSEQ/SEQ address phase is accepted, HWDATA SHALL load the FIFO head and the FIFO SHALL pop, so HWDATA lags its address by one cycle.
REQ-030 If a later write beat finds the FIFO empty, the block SHALL drive HTRANS=BUSY with HADDR held and resume SEQ once the FIFO is non-empty.
REQ-031 Read data phase: when HREADY=1, rdata_top SHALL load HRDATA and rdata_valid SHALL pulse for one cycle.
REQ-032 After the last beat is accepted the block SHALL drive HTRANS=IDLE and return to IDLE, keeping HWDATA valid for the final data phase; a new burst may start the following cycle.

Reset
REQ-033 While RESET_MASTER=0, outputs SHALL be: HADDR=0, HTRANS=00, HWRITE=0, HSIZE=010, HBURST=000, HWDATA=0, rdata_top=0, rdata_valid=0, fifo_empty=1, fifo_full=0, with the FIFO pointers and count cleared and the state IDLE.
REQ-034 Reset asserted mid-burst SHALL abort the burst immediately and discard all FIFO contents.

Verification
REQ-035 Reset: assert RESET_MASTER=0 at any time -> all REQ-033 values within the same cycle.
REQ-036 INCR4 write: push 0x00000001, 0x12341234, 0x00000000, 0x00000002, then enb=1, addr_top=0x0, beat_length=4, wrap_enb=0, HREADY=1 -> HADDR 0x0, 0x4, 0x8, 0xC; HTRANS 10, 11, 11, 11; HBURST=011; HWDATA 0x00000001, 0x12341234, 0x00000000, 0x00000002, each one cycle later; then HTRANS=00.
REQ-037 WRAP4 read: addr_top=0x38, beat_length=4, wrap_enb=1, write_top=0 -> HADDR 0x38, 0x3C, 0x30, 0x34; HBURST=010; rdata_valid pulses 4 times.
REQ-038 Stall: HREADY=0 for 3 cycles during beat 2 -> HADDR, HTRANS and HWDATA held for 3 cycles, then the burst completes unchanged.
REQ-039 FIFO: 17 consecutive pushes -> fifo_full=1 after the 16th and the 17th value is never driven on HWDATA.
REQ-040 Underflow: INCR8 write with only 3 words pushed -> beat 4 shows HTRANS=01 with HADDR held until the next push, then SEQ resumes.

Source files
------------

// File: rtl/ahb_master_burst.sv
// rtl/ahb_master_burst.sv - AHB-Lite burst master with a 16x32 write-data FIFO
module ahb_master_burst (
    input  logic        CLK_MASTER,
    input  logic        RESET_MASTER,
    input  logic        HREADY,
    input  logic [31:0] HRDATA,
    input  logic [31:0] data_top,
    input  logic [31:0] addr_top,
    input  logic        write_top,
    input  logic [3:0]  beat_length,
    input  logic        enb,
    input  logic        wrap_enb,
    output logic [31:0] HADDR,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [1:0]  HTRANS,
    output logic [31:0] HWDATA,
    output logic        fifo_full,
    output logic        fifo_empty,
    output logic [31:0] rdata_top,
    output logic        rdata_valid
);
    typedef enum logic [1:0] {S_IDLE, S_NONSEQ, S_SEQ, S_BUSY} state_t;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    state_t      state_q, state_d;
    logic [31:0] haddr_q, haddr_d;
    logic        hwrite_q, hwrite_d;
    logic [2:0]  hburst_q, hburst_d;
    logic [1:0]  htrans_q, htrans_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic [4:0]  beats_left_q, beats_left_d;
    logic [3:0]  len_q, len_d;
    logic        wrap_q, wrap_d;
    logic        dp_read_q, dp_read_d;
    logic [3:0]  wr_ptr_q, wr_ptr_d;
    logic [3:0]  rd_ptr_q, rd_ptr_d;
    logic [4:0]  count_q, count_d;
    logic        full_q, full_d;
    logic        empty_q, empty_d;
    logic [31:0] mem_q [16];

    logic        push, accept, pop;
    logic [31:0] wrap_mask, next_addr;

    function automatic logic [2:0] burst_code(input logic [3:0] len, input logic wrap);
        case (len)
            4'd1:    burst_code = 3'b000;
            4'd4:    burst_code = wrap ? 3'b010 : 3'b011;
            4'd8:    burst_code = wrap ? 3'b100 : 3'b101;
            4'd0:    burst_code = wrap ? 3'b110 : 3'b111;
            default: burst_code = 3'b001;
        endcase
    endfunction

    assign push   = write_top && !full_q;
    assign accept = HREADY && ((state_q == S_NONSEQ) || (state_q == S_SEQ));
    assign pop    = accept && hwrite_q;

    // Only the three fixed-length sizes wrap; a zero mask selects plain increment.
    always_comb begin
        case (len_q)
            4'd4:    wrap_mask = 32'h0000_000F;
            4'd8:    wrap_mask = 32'h0000_001F;
            4'd0:    wrap_mask = 32'h0000_003F;
            default: wrap_mask = 32'h0000_0000;
        endcase
        if (wrap_q && (wrap_mask != 32'd0)) begin
            next_addr = (haddr_q & ~wrap_mask) | ((haddr_q + 32'd4) & wrap_mask);
        end else begin
            next_addr = haddr_q + 32'd4;
        end
    end

    always_comb begin
        state_d      = state_q;
        haddr_d      = haddr_q;
        hwrite_d     = hwrite_q;
        hburst_d     = hburst_q;
        hwdata_d     = hwdata_q;
        rdata_d      = rdata_q;
        rvalid_d     = 1'b0;
        beats_left_d = beats_left_q;
        len_d        = len_q;
        wrap_d       = wrap_q;
        dp_read_d    = dp_read_q;

        count_d  = count_q + {4'd0, push} - {4'd0, pop};
        wr_ptr_d = wr_ptr_q + {3'd0, push};
        rd_ptr_d = rd_ptr_q + {3'd0, pop};
        full_d   = (count_d == 5'd16);
        empty_d  = (count_d == 5'd0);

        if (HREADY) begin
            if (dp_read_q) begin
                rdata_d  = HRDATA;
                rvalid_d = 1'b1;
            end
            dp_read_d = accept && !hwrite_q;
        end

        case (state_q)
            S_IDLE: begin
                if (enb && !(write_top && empty_q)) begin
                    state_d      = S_NONSEQ;
                    haddr_d      = addr_top;
                    hwrite_d     = write_top;
                    len_d        = beat_length;
                    wrap_d       = wrap_enb;
                    hburst_d     = burst_code(beat_length, wrap_enb);
                    beats_left_d = (beat_length == 4'd0) ? 5'd16 : {1'b0, beat_length};
                end
            end
            S_NONSEQ, S_SEQ: begin
                if (HREADY) begin
                    if (pop) begin
                        hwdata_d = mem_q[rd_ptr_q];
                    end
                    if (beats_left_q == 5'd1) begin
                        state_d = S_IDLE;
                    end else begin
                        haddr_d      = next_addr;
                        beats_left_d = beats_left_q - 5'd1;
                        state_d      = (hwrite_q && (count_d == 5'd0)) ? S_BUSY : S_SEQ;
                    end
                end
            end
            S_BUSY: begin
                if (HREADY && !empty_q) begin
                    state_d = S_SEQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_NONSEQ: htrans_d = TR_NONSEQ;
            S_SEQ:    htrans_d = TR_SEQ;
            S_BUSY:   htrans_d = TR_BUSY;
            default:  htrans_d = TR_IDLE;
        endcase
    end

    always_ff @(posedge CLK_MASTER or negedge RESET_MASTER) begin
        if (!RESET_MASTER) begin
            state_q      <= S_IDLE;
            haddr_q      <= 32'd0;
            hwrite_q     <= 1'b0;
            hburst_q     <= 3'b000;
            htrans_q     <= TR_IDLE;
            hwdata_q     <= 32'd0;
            rdata_q      <= 32'd0;
            rvalid_q     <= 1'b0;
            beats_left_q <= 5'd0;
            len_q        <= 4'd0;
            wrap_q       <= 1'b0;
            dp_read_q    <= 1'b0;
            wr_ptr_q     <= 4'd0;
            rd_ptr_q     <= 4'd0;
            count_q      <= 5'd0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            haddr_q      <= haddr_d;
            hwrite_q     <= hwrite_d;
            hburst_q     <= hburst_d;
            htrans_q     <= htrans_d;
            hwdata_q     <= hwdata_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
            beats_left_q <= beats_left_d;
            len_q        <= len_d;
            wrap_q       <= wrap_d;
            dp_read_q    <= dp_read_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
        end
    end

    // Storage needs no reset: clearing the pointers and count discards the contents.
    always_ff @(posedge CLK_MASTER) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_top;
        end
    end

    assign HADDR       = haddr_q;
    assign HWRITE      = hwrite_q;
    assign HSIZE       = 3'b010;
    assign HBURST      = hburst_q;
    assign HTRANS      = htrans_q;
    assign HWDATA      = hwdata_q;
    assign fifo_full   = full_q;
    assign fifo_empty  = empty_q;
    assign rdata_top   = rdata_q;
    assign rdata_valid = rvalid_q;
endmodule

// File: tb/tb_ahb_master_burst.sv
// tb/tb_ahb_master_burst.sv - scoreboard bench for ahb_master_burst
module tb_ahb_master_burst;
    logic        CLK_MASTER = 1'b0;
    logic        RESET_MASTER = 1'b0;
    logic        HREADY = 1'b1;
    logic [31:0] HRDATA = 32'd0;
    logic [31:0] data_top = 32'd0;
    logic [31:0] addr_top = 32'd0;
    logic        write_top = 1'b0;
    logic [3:0]  beat_length = 4'd0;
    logic        enb = 1'b0;
    logic        wrap_enb = 1'b0;
    logic [31:0] HADDR, HWDATA, rdata_top;
    logic        HWRITE, fifo_full, fifo_empty, rdata_valid;
    logic [2:0]  HSIZE, HBURST;
    logic [1:0]  HTRANS;

    ahb_master_burst dut (
        .CLK_MASTER(CLK_MASTER), .RESET_MASTER(RESET_MASTER), .HREADY(HREADY),
        .HRDATA(HRDATA), .data_top(data_top), .addr_top(addr_top),
        .write_top(write_top), .beat_length(beat_length), .enb(enb),
        .wrap_enb(wrap_enb), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HTRANS(HTRANS), .HWDATA(HWDATA),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .rdata_top(rdata_top), .rdata_valid(rdata_valid)
    );

    always #5 CLK_MASTER = ~CLK_MASTER;

    typedef struct {
        logic [31:0] addr;
        logic        first;
        logic [2:0]  burst;
        logic        wr;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] mfifo[$];
    logic [31:0] rexp[$];
    logic [31:0] wlog[$];
    logic [31:0] alog[$];
    int          errors = 0;
    int          checks = 0;
    logic        wd_pend = 0, rd_pend = 0;
    logic [31:0] wd_exp = 0;
    logic        prev_stall = 0, prev_busy = 0, prev_busy_exit = 0;
    logic [31:0] prev_addr = 0;
    logic [1:0]  prev_trans = 0;
    int          beats_seen = 0, stall_seen = 0, rv_count = 0;
    int          m_sz;
    logic        m_active;
    beat_t       m_beat;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge CLK_MASTER);
        #1;
    endtask

    task automatic clear_model();
        exp_q.delete(); mfifo.delete(); rexp.delete(); wlog.delete(); alog.delete();
        wd_pend = 0; rd_pend = 0; prev_stall = 0; prev_busy = 0; prev_busy_exit = 0;
        beats_seen = 0; stall_seen = 0; rv_count = 0;
    endtask

    // Asserted between edges; the outputs must already be in their reset state 1ns later.
    task automatic do_reset();
        RESET_MASTER = 1'b0;
        #1;
        chk(HADDR == 32'd0, "rst_haddr", HADDR, 32'd0);
        chk(HTRANS == 2'b00, "rst_htrans", 32'(HTRANS), 32'd0);
        chk(HWRITE == 1'b0, "rst_hwrite", 32'(HWRITE), 32'd0);
        chk(HSIZE == 3'b010, "rst_hsize", 32'(HSIZE), 32'd2);
        chk(HBURST == 3'b000, "rst_hburst", 32'(HBURST), 32'd0);
        chk(HWDATA == 32'd0, "rst_hwdata", HWDATA, 32'd0);
        chk(rdata_top == 32'd0, "rst_rdata_top", rdata_top, 32'd0);
        chk(rdata_valid == 1'b0, "rst_rdata_valid", 32'(rdata_valid), 32'd0);
        chk(fifo_empty == 1'b1, "rst_fifo_empty", 32'(fifo_empty), 32'd1);
        chk(fifo_full == 1'b0, "rst_fifo_full", 32'(fifo_full), 32'd0);
        clear_model();
        enb = 0; write_top = 0; HREADY = 1;
        step();
        step();
        RESET_MASTER = 1'b1;
        step();
    endtask

    task automatic push_word(input logic [31:0] d);
        write_top = 1; data_top = d; enb = 0; HREADY = 1;
        step();
        write_top = 0;
    endtask

    // Expected beats come straight from the address rules: offset modulo burst size for wraps.
    task automatic start_burst(input logic [31:0] addr, input logic wr, input logic [3:0] len,
                               input logic wrap, input logic [31:0] d);
        int          n;
        logic        wr_eff;
        logic [2:0]  b;
        logic [31:0] sz, base;
        beat_t       e;
        n = (len == 4'd0) ? 16 : int'(len);
        wr_eff = wrap && (n == 4 || n == 8 || n == 16);
        if (n == 1)       b = 3'b000;
        else if (n == 4)  b = wrap ? 3'b010 : 3'b011;
        else if (n == 8)  b = wrap ? 3'b100 : 3'b101;
        else if (n == 16) b = wrap ? 3'b110 : 3'b111;
        else              b = 3'b001;
        sz = 32'(4 * n);
        base = addr - (addr % sz);
        for (int i = 0; i < n; i++) begin
            e.addr  = wr_eff ? base + ((addr - base + 32'(4 * i)) % sz) : addr + 32'(4 * i);
            e.first = (i == 0);
            e.burst = b;
            e.wr    = wr;
            exp_q.push_back(e);
        end
        beats_seen = 0;
        enb = 1; addr_top = addr; write_top = wr; beat_length = len; wrap_enb = wrap;
        data_top = d; HREADY = 1;
        step();
        enb = 0; write_top = 0;
    endtask

    task automatic wait_done(input int budget, input int hr_pct, input int push_pct, input int stall_at);
        int cyc = 0;
        int stall_left = 0;
        bit stalled = 0;
        while (exp_q.size() != 0 && cyc < budget) begin
            if (stall_at > 0 && !stalled && beats_seen == stall_at) begin
                stalled = 1;
                stall_left = 3;
            end
            if (stall_left > 0) begin
                HREADY = 0;
                stall_left--;
            end else begin
                HREADY = (int'($urandom_range(99)) < hr_pct);
            end
            write_top = (int'($urandom_range(99)) < push_pct);
            data_top = $urandom;
            HRDATA = $urandom;
            enb = 0;
            step();
            cyc++;
        end
        chk(exp_q.size() == 0, "burst_timeout", 32'(exp_q.size()), 32'd0);
        if (exp_q.size() != 0) do_reset();
        HREADY = 1;
        write_top = 0;
    endtask

    always @(negedge CLK_MASTER) begin
        if (RESET_MASTER) begin
            m_sz = mfifo.size();
            m_active = (HTRANS == 2'b10) || (HTRANS == 2'b11);
            chk(fifo_full == (m_sz == 16), "fifo_full", 32'(fifo_full), 32'(m_sz == 16));
            chk(fifo_empty == (m_sz == 0), "fifo_empty", 32'(fifo_empty), 32'(m_sz == 0));
            if (prev_stall) begin
                chk(HADDR == prev_addr, "stall_hold_haddr", HADDR, prev_addr);
                chk(HTRANS == prev_trans, "stall_hold_htrans", 32'(HTRANS), 32'(prev_trans));
            end
            if (rexp.size() != 0) begin
                chk(rdata_valid == 1'b1, "rdata_valid_pulse", 32'(rdata_valid), 32'd1);
                chk(rdata_top == rexp[0], "rdata_top", rdata_top, rexp[0]);
                void'(rexp.pop_front());
            end else begin
                chk(rdata_valid == 1'b0, "rdata_valid_idle", 32'(rdata_valid), 32'd0);
            end
            if (rdata_valid) rv_count++;
            if (wd_pend) begin
                chk(HWDATA == wd_exp, "hwdata", HWDATA, wd_exp);
                if (HREADY) begin
                    wlog.push_back(HWDATA);
                    wd_pend = 0;
                end
            end
            if (rd_pend && HREADY) begin
                rexp.push_back(HRDATA);
                rd_pend = 0;
            end
            if (HTRANS == 2'b01) begin
                if (!prev_busy) chk(m_sz == 0, "busy_entry_fifo_count", 32'(m_sz), 32'd0);
                chk(HWRITE == 1'b1, "busy_hwrite", 32'(HWRITE), 32'd1);
                chk(exp_q.size() != 0, "busy_in_burst", 32'(exp_q.size()), 32'd1);
                if (exp_q.size() != 0) chk(HADDR == exp_q[0].addr, "busy_haddr", HADDR, exp_q[0].addr);
            end
            if (prev_busy_exit) chk(HTRANS != 2'b01, "busy_exit", 32'(HTRANS), 32'd3);
            prev_busy_exit = (HTRANS == 2'b01) && HREADY && (m_sz != 0);
            prev_busy = (HTRANS == 2'b01);
            if (HREADY && m_active) begin
                chk(exp_q.size() != 0, "beat_expected", 32'(exp_q.size()), 32'd1);
                if (exp_q.size() != 0) begin
                    m_beat = exp_q.pop_front();
                    chk(HADDR == m_beat.addr, "haddr", HADDR, m_beat.addr);
                    chk(HTRANS == (m_beat.first ? 2'b10 : 2'b11), "htrans", 32'(HTRANS),
                        m_beat.first ? 32'd2 : 32'd3);
                    chk(HBURST == m_beat.burst, "hburst", 32'(HBURST), 32'(m_beat.burst));
                    chk(HWRITE == m_beat.wr, "hwrite", 32'(HWRITE), 32'(m_beat.wr));
                    chk(HSIZE == 3'b010, "hsize", 32'(HSIZE), 32'd2);
                    alog.push_back(HADDR);
                    beats_seen++;
                    if (m_beat.wr) begin
                        chk(mfifo.size() != 0, "write_beat_has_data", 32'(mfifo.size()), 32'd1);
                        if (mfifo.size() != 0) begin
                            wd_exp = mfifo.pop_front();
                            wd_pend = 1;
                        end
                    end else begin
                        rd_pend = 1;
                    end
                end
            end
            if (!HREADY && m_active) stall_seen++;
            prev_stall = !HREADY && (HTRANS != 2'b00);
            prev_addr = HADDR;
            prev_trans = HTRANS;
            if (write_top && m_sz < 16) mfifo.push_back(data_top);
        end
    end

    initial begin
        logic [31:0] exp4 [4];
        logic [31:0] wrap_addrs [4];
        logic [31:0] a;
        logic        wr;
        step();
        step();
        do_reset();

        // INCR4 write with fixed data
        exp4[0] = 32'h0000_0001; exp4[1] = 32'h1234_1234; exp4[2] = 32'h0000_0000; exp4[3] = 32'h0000_0002;
        for (int i = 0; i < 4; i++) push_word(exp4[i]);
        start_burst(32'h0, 1'b1, 4'd4, 1'b0, 32'h5555_5555);
        wait_done(200, 100, 0, 0);
        step();
        chk(HTRANS == 2'b00, "incr4_end_idle", 32'(HTRANS), 32'd0);
        chk(wlog.size() == 4, "incr4_wcount", 32'(wlog.size()), 32'd4);
        for (int i = 0; i < 4 && i < wlog.size(); i++) begin
            chk(wlog[i] == exp4[i], "incr4_hwdata", wlog[i], exp4[i]);
            chk(alog[i] == 32'(4 * i), "incr4_haddr", alog[i], 32'(4 * i));
        end

        // WRAP4 read
        do_reset();
        wrap_addrs[0] = 32'h38; wrap_addrs[1] = 32'h3C; wrap_addrs[2] = 32'h30; wrap_addrs[3] = 32'h34;
        start_burst(32'h38, 1'b0, 4'd4, 1'b1, 32'h0);
        wait_done(200, 100, 0, 0);
        step();
        step();
        chk(alog.size() == 4, "wrap4_beats", 32'(alog.size()), 32'd4);
        for (int i = 0; i < 4 && i < alog.size(); i++)
            chk(alog[i] == wrap_addrs[i], "wrap4_haddr", alog[i], wrap_addrs[i]);
        chk(rv_count == 4, "wrap4_rdata_pulses", 32'(rv_count), 32'd4);

        // Three-cycle stall on beat 2
        do_reset();
        for (int i = 0; i < 3; i++) push_word(32'hB000_0000 + 32'(i));
        start_burst(32'h200, 1'b1, 4'd4, 1'b0, 32'hB000_0003);
        wait_done(200, 100, 0, 1);
        step();
        chk(stall_seen == 3, "stall_cycles", 32'(stall_seen), 32'd3);
        chk(wlog.size() == 4, "stall_wcount", 32'(wlog.size()), 32'd4);
        for (int i = 0; i < 4 && i < wlog.size(); i++)
            chk(wlog[i] == 32'hB000_0000 + 32'(i), "stall_hwdata", wlog[i], 32'hB000_0000 + 32'(i));

        // 17 pushes: the last one is dropped
        do_reset();
        for (int i = 0; i < 17; i++) begin
            push_word(32'hA000_0000 + 32'(i));
            if (i == 14) chk(fifo_full == 1'b0, "fifo_not_full_15", 32'(fifo_full), 32'd0);
            if (i == 15) chk(fifo_full == 1'b1, "fifo_full_16", 32'(fifo_full), 32'd1);
        end
        start_burst(32'h100, 1'b1, 4'd0, 1'b0, 32'hBAD0_0000);
        wait_done(300, 100, 0, 0);
        step();
        chk(wlog.size() == 16, "incr16_wcount", 32'(wlog.size()), 32'd16);
        for (int i = 0; i < wlog.size(); i++) begin
            chk(wlog[i] == 32'hA000_0000 + 32'(i), "incr16_hwdata", wlog[i], 32'hA000_0000 + 32'(i));
            chk(wlog[i] != 32'hA000_0010, "dropped_word_absent", wlog[i], 32'hA000_0010);
        end
        chk(fifo_empty == 1'b1, "incr16_drained", 32'(fifo_empty), 32'd1);

        // INCR8 write with three words: beat 4 goes BUSY
        do_reset();
        push_word(32'hC1); push_word(32'hC2);
        start_burst(32'h400, 1'b1, 4'd8, 1'b0, 32'hC3);
        HREADY = 1; write_top = 0;
        for (int i = 0; i < 50 && HTRANS != 2'b01; i++) step();
        chk(HTRANS == 2'b01, "underflow_busy", 32'(HTRANS), 32'd1);
        chk(beats_seen == 3, "underflow_beat_index", 32'(beats_seen), 32'd3);
        chk(HADDR == 32'h40C, "underflow_haddr", HADDR, 32'h40C);
        for (int i = 0; i < 3; i++) begin
            step();
            chk(HTRANS == 2'b01 && HADDR == 32'h40C, "underflow_hold", HADDR, 32'h40C);
        end
        wait_done(500, 100, 40, 0);
        step();
        chk(wlog.size() == 8, "underflow_wcount", 32'(wlog.size()), 32'd8);

        // Reset in the middle of a burst
        do_reset();
        for (int i = 0; i < 8; i++) push_word($urandom);
        start_burst(32'h800, 1'b1, 4'd8, 1'b0, $urandom);
        for (int i = 0; i < 20 && beats_seen < 2; i++) step();
        chk(beats_seen >= 2, "midburst_progress", 32'(beats_seen), 32'd2);
        do_reset();

        // Randomized bursts
        for (int n = 0; n < 30; n++) begin
            wr = 1'($urandom_range(1));
            a = $urandom & 32'hFFFF_FFFC;
            if (wr) begin
                for (int k = 0; k < int'($urandom_range(4)); k++) push_word($urandom);
                if (mfifo.size() == 0) push_word($urandom);
            end
            start_burst(a, wr, 4'($urandom_range(15)), 1'($urandom_range(1)), $urandom);
            wait_done(2000, 70, 30, 0);
        end
        step();
        step();
        chk(exp_q.size() == 0 && rexp.size() == 0 && !wd_pend && !rd_pend, "scoreboard_drained",
            32'(exp_q.size() + rexp.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
